// File: rtl/mem_access_pkg.sv
// mem_defs: shared memop/size codes, FSM state type and helpers for the memory-stage access unit
//   MEMOP_*  : load/store operation codes carried by memopM
//   SIZE_*   : data_size bus codes
//   memState_t : access FSM states
package mem_defs;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_BU = 3'b001;
    localparam logic [2:0] MEMOP_H  = 3'b010;
    localparam logic [2:0] MEMOP_HU = 3'b011;
    localparam logic [2:0] MEMOP_W  = 3'b100;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        DONE
    } memState_t;

    // Codes above MEMOP_W are treated as word accesses.
    function automatic logic [1:0] sizeOf(input logic [2:0] memop);
        return memop[2] ? SIZE_W : memop[1] ? SIZE_H : SIZE_B;
    endfunction

    function automatic logic isMisaligned(input logic [2:0] memop, input logic [1:0] a);
        return (sizeOf(memop) == SIZE_H && a[0]) || (sizeOf(memop) == SIZE_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half lane of a read word and sign/zero extends it
//   rdata    : raw 32-bit bus read word
//   a        : low two bits of the access address
//   memop    : load operation code (B, BU, H, HU, W)
//   readdata : aligned, extended load result
module mem_load_align
    import mem_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  memop,
    output logic [31:0] readdata
);

    logic [31:0] shifted;
    logic [7:0]  byteV;
    logic [15:0] halfV;
    logic        signExt;

    always_comb begin
        shifted  = rdata >> {a, 3'b000};
        byteV    = shifted[7:0];
        halfV    = a[1] ? rdata[31:16] : rdata[15:0];
        // Odd codes (BU, HU) are the unsigned variants.
        signExt  = ~memop[0];
        readdata = sizeOf(memop) == SIZE_W ? rdata :
                   sizeOf(memop) == SIZE_H ? {{16{signExt & halfV[15]}}, halfV} :
                                             {{24{signExt & byteV[7]}}, byteV};
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-stage data-access unit between EX/MEM and MEM/WB
//   Pipeline side : flushM, memenM, memwriteM, memopM, aluoutM, writedataM in;
//                   readdataM, stallM, adelM, adesM, badvaddrM out
//   Data bus      : data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata out;
//                   data_addr_ok, data_data_ok, data_rdata in
//   clk / reset   : single clock, synchronous active-high reset
module mem_access
    import mem_defs::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flushM,
    input  logic              memenM,
    input  logic              memwriteM,
    input  logic [2:0]        memopM,
    input  logic [ADDR_W-1:0] aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              adelM,
    output logic              adesM,
    output logic [ADDR_W-1:0] badvaddrM,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    memState_t         state, stateN;
    logic              misaligned, issue, capture;
    logic [1:0]        sizeN;
    logic [3:0]        wstrbN;
    logic [31:0]       wdataN, alignedData;
    logic              wrQ, killedQ;
    logic [1:0]        sizeQ;
    logic [2:0]        memopQ;
    logic [ADDR_W-1:0] addrQ;
    logic [3:0]        wstrbQ;
    logic [31:0]       wdataQ, readQ;

    always_comb begin
        misaligned = isMisaligned(memopM, aluoutM[1:0]);
        issue      = state == IDLE && memenM && !misaligned && !flushM;
        adelM      = state == IDLE && memenM && !memwriteM && misaligned;
        adesM      = state == IDLE && memenM && memwriteM && misaligned;
        badvaddrM  = aluoutM;
        sizeN      = sizeOf(memopM);
        wstrbN     = !memwriteM       ? 4'b0000 :
                     sizeN == SIZE_W  ? 4'b1111 :
                     sizeN == SIZE_H  ? (aluoutM[1] ? 4'b1100 : 4'b0011) :
                                        4'b0001 << aluoutM[1:0];
        wdataN     = sizeN == SIZE_W ? writedataM :
                     sizeN == SIZE_H ? {2{writedataM[15:0]}} :
                                       {4{writedataM[7:0]}};
        capture    = state == DATA && data_data_ok && !flushM;
    end

    // The request goes out in the same cycle it is decided, so the bus sees the
    // live fields while issuing and the latched copies for the rest of the access.
    always_comb begin
        data_req   = issue || state == ADDR;
        data_wr    = issue ? memwriteM : wrQ;
        data_size  = issue ? sizeN : sizeQ;
        data_addr  = issue ? aluoutM : addrQ;
        data_wstrb = issue ? wstrbN : wstrbQ;
        data_wdata = issue ? wdataN : wdataQ;
        readdataM  = readQ;
    end

    always_comb begin
        stateN = state;
        stallM = 1'b0;
        case (state)
            IDLE: begin
                stallM = issue;
                if (issue)
                    stateN = data_addr_ok ? DATA : ADDR;
            end
            ADDR: begin
                stallM = 1'b1;
                // A request already on the bus cannot be withdrawn; a flush only
                // decides whether its response is kept or drained.
                if (data_addr_ok)
                    stateN = (killedQ || flushM) ? DRAIN : DATA;
            end
            DATA: begin
                stallM = 1'b1;
                if (data_data_ok)
                    stateN = flushM ? IDLE : DONE;
                else if (flushM)
                    stateN = DRAIN;
            end
            DRAIN: begin
                stallM = 1'b1;
                if (data_data_ok)
                    stateN = IDLE;
            end
            DONE:    stateN = IDLE;
            default: stateN = IDLE;
        endcase
    end

    mem_load_align uAlign (
        .rdata    (data_rdata),
        .a        (addrQ[1:0]),
        .memop    (memopQ),
        .readdata (alignedData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            killedQ <= 1'b0;
            wrQ     <= 1'b0;
            sizeQ   <= '0;
            memopQ  <= '0;
            addrQ   <= '0;
            wstrbQ  <= '0;
            wdataQ  <= '0;
            readQ   <= '0;
        end else begin
            state   <= stateN;
            killedQ <= state == ADDR && (killedQ || flushM);
            if (issue) begin
                wrQ    <= memwriteM;
                sizeQ  <= sizeN;
                memopQ <= memopM;
                addrQ  <= aluoutM;
                wstrbQ <= wstrbN;
                wdataQ <= wdataN;
            end
            if (capture)
                readQ <= wrQ ? 32'h0 : alignedData;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access with hand-computed expectations
module tb_mem_access;
    import mem_defs::*;

    logic        clk, reset, flushM, memenM, memwriteM;
    logic [2:0]  memopM;
    logic [31:0] aluoutM, writedataM, readdataM, badvaddrM;
    logic        stallM, adelM, adesM;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    int          nPass, nTotal;

    mem_access #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .flushM       (flushM),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .memopM       (memopM),
        .aluoutM      (aluoutM),
        .writedataM   (writedataM),
        .readdataM    (readdataM),
        .stallM       (stallM),
        .adelM        (adelM),
        .adesM        (adesM),
        .badvaddrM    (badvaddrM),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wstrb   (data_wstrb),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTotal++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with addr_ok on the issue cycle and data_ok one cycle later.
    task automatic doLoad(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp);
        memenM = 1; memwriteM = 0; memopM = op; aluoutM = addr; data_addr_ok = 1;
        #1;
        checkEq({tag, " req"}, 32'(data_req), 32'd1);
        checkEq({tag, " stall0"}, 32'(stallM), 32'd1);
        tick();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = rdata;
        #1;
        checkEq({tag, " stall1"}, 32'(stallM), 32'd1);
        checkEq({tag, " reqOff"}, 32'(data_req), 32'd0);
        tick();
        data_data_ok = 0; memenM = 0;
        #1;
        checkEq({tag, " stallDone"}, 32'(stallM), 32'd0);
        checkEq({tag, " data"}, readdataM, exp);
        tick();
    endtask

    initial begin
        nPass = 0; nTotal = 0;
        reset = 1; flushM = 0; memenM = 0; memwriteM = 0; memopM = 0; aluoutM = 0;
        writedataM = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = 0;
        tick(); tick();
        reset = 0;
        #1;
        checkEq("rst stall", 32'(stallM), 32'd0);
        checkEq("rst req", 32'(data_req), 32'd0);
        checkEq("rst rdata", readdataM, 32'h0);
        checkEq("rst addr", data_addr, 32'h0);
        checkEq("rst wstrb", 32'(data_wstrb), 32'h0);
        tick();

        doLoad("LB", MEMOP_B, 32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80);
        doLoad("LBU", MEMOP_BU, 32'h1001, 32'h0000_8000, 32'h0000_0080);
        doLoad("LH", MEMOP_H, 32'h0002, 32'h9ABC_1234, 32'hFFFF_9ABC);
        doLoad("LHU", MEMOP_HU, 32'h0002, 32'h9ABC_1234, 32'h0000_9ABC);
        doLoad("LHU lo", MEMOP_HU, 32'h0000, 32'h9ABC_F234, 32'h0000_F234);
        doLoad("LW", MEMOP_W, 32'h7000, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // SH @0x2002
        memenM = 1; memwriteM = 1; memopM = MEMOP_H; aluoutM = 32'h2002;
        writedataM = 32'h0000_BEEF; data_addr_ok = 1;
        #1;
        checkEq("SH req", 32'(data_req), 32'd1);
        checkEq("SH wr", 32'(data_wr), 32'd1);
        checkEq("SH size", 32'(data_size), 32'd1);
        checkEq("SH wstrb", 32'(data_wstrb), 32'hC);
        checkEq("SH wdata", data_wdata, 32'hBEEF_BEEF);
        tick();
        data_addr_ok = 0; data_data_ok = 1;
        #1;
        checkEq("SH stall", 32'(stallM), 32'd1);
        tick();
        data_data_ok = 0; memenM = 0;
        #1;
        checkEq("SH done stall", 32'(stallM), 32'd0);
        checkEq("SH readdata", readdataM, 32'h0);
        tick();

        // Misaligned LW / SW
        memenM = 1; memwriteM = 0; memopM = MEMOP_W; aluoutM = 32'h3001;
        #1;
        checkEq("LW mis adel", 32'(adelM), 32'd1);
        checkEq("LW mis ades", 32'(adesM), 32'd0);
        checkEq("LW mis badv", badvaddrM, 32'h3001);
        checkEq("LW mis req", 32'(data_req), 32'd0);
        checkEq("LW mis stall", 32'(stallM), 32'd0);
        tick();
        checkEq("LW mis req2", 32'(data_req), 32'd0);
        memwriteM = 1; aluoutM = 32'h3002;
        #1;
        checkEq("SW mis ades", 32'(adesM), 32'd1);
        checkEq("SW mis adel", 32'(adelM), 32'd0);
        memopM = MEMOP_H; aluoutM = 32'h3003;
        #1;
        checkEq("SH mis ades", 32'(adesM), 32'd1);
        memopM = MEMOP_B;
        #1;
        checkEq("SB odd ok", 32'(adesM), 32'd0);
        memenM = 0;
        tick();

        // SB @0x4001 with addr_ok low for three cycles
        memenM = 1; memwriteM = 1; memopM = MEMOP_B; aluoutM = 32'h4001;
        writedataM = 32'h0000_00A5; data_addr_ok = 0;
        #1;
        checkEq("SB wstrb", 32'(data_wstrb), 32'h2);
        checkEq("SB wdata", data_wdata, 32'hA5A5_A5A5);
        tick();
        aluoutM = 32'hDEAD_0000; writedataM = 32'h0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) data_addr_ok = 1;
            #1;
            checkEq("hold req", 32'(data_req), 32'd1);
            checkEq("hold addr", data_addr, 32'h4001);
            checkEq("hold wdata", data_wdata, 32'hA5A5_A5A5);
            checkEq("hold wstrb", 32'(data_wstrb), 32'h2);
            checkEq("hold stall", 32'(stallM), 32'd1);
            tick();
        end
        data_addr_ok = 0; data_data_ok = 1;
        #1;
        checkEq("SB data stall", 32'(stallM), 32'd1);
        tick();
        data_data_ok = 0; memenM = 0;
        #1;
        checkEq("SB done stall", 32'(stallM), 32'd0);
        tick();

        // Flush in DATA, data_ok two cycles later
        memenM = 1; memwriteM = 0; memopM = MEMOP_W; aluoutM = 32'h5000; data_addr_ok = 1;
        tick();
        data_addr_ok = 0; flushM = 1;
        #1;
        checkEq("flush stall", 32'(stallM), 32'd1);
        tick();
        flushM = 0; aluoutM = 32'h6000;
        #1;
        checkEq("drain stall1", 32'(stallM), 32'd1);
        checkEq("drain req1", 32'(data_req), 32'd0);
        tick();
        data_data_ok = 1; data_rdata = 32'h1234_5678;
        #1;
        checkEq("drain stall2", 32'(stallM), 32'd1);
        checkEq("drain req2", 32'(data_req), 32'd0);
        tick();
        data_data_ok = 0;
        #1;
        checkEq("drain kept old", readdataM, 32'h0);
        checkEq("post drain req", 32'(data_req), 32'd1);
        checkEq("post drain addr", data_addr, 32'h6000);
        data_addr_ok = 1;
        tick();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1122_3344;
        tick();
        data_data_ok = 0; memenM = 0;
        #1;
        checkEq("post drain data", readdataM, 32'h1122_3344);
        tick();

        // Reset while in DATA
        memenM = 1; memwriteM = 0; memopM = MEMOP_HU; aluoutM = 32'h0002; data_addr_ok = 1;
        tick();
        reset = 1; memenM = 0; data_addr_ok = 0;
        tick();
        reset = 0;
        #1;
        checkEq("rstDATA stall", 32'(stallM), 32'd0);
        checkEq("rstDATA req", 32'(data_req), 32'd0);
        checkEq("rstDATA rdata", readdataM, 32'h0);
        tick();

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
